// File: rtl/multi_channel_pulse_counter.sv
// rtl/multi_channel_pulse_counter.sv - N-channel edge counter with atomic snapshot readout stream
module multi_channel_pulse_counter #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int EDGE_MODE = 0,
    parameter int SATURATE  = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pulse,
    input  logic              en_count,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              clear,
    input  logic              snap_req,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [NUM_CH-1:0] ovf
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   pulse_d;
    logic [NUM_CH-1:0]   evt;
    logic [NUM_CH-1:0]   inc;
    logic [NUM_CH-1:0]   ovf_r;
    logic [CNT_W-1:0]    cnt    [NUM_CH];
    logic [CNT_W-1:0]    shadow [NUM_CH];
    logic [CH_W-1:0]     ch_r;
    logic                last_ch;

    // Previous pulse level; loading it during reset keeps an already-high level from counting
    always_ff @(posedge clk) begin
        pulse_d <= pulse;
    end

    // Select which transitions count as events
    always_comb begin
        case (EDGE_MODE)
            1:       evt = ~pulse & pulse_d;
            2:       evt = pulse ^ pulse_d;
            default: evt = pulse & ~pulse_d;
        endcase
    end

    assign inc = evt & ch_en & {NUM_CH{en_count}};

    // Live counters with wrap/saturate and sticky overflow; clear wins over an increment
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (inc[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf_r[i] <= 1'b1;
                        cnt[i]   <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign ovf     = ovf_r;
    assign last_ch = (ch_r == LAST_CH);
    assign rd_ch   = ch_r;

    // Readout state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Readout next state and stream outputs
    always_comb begin
        state_nxt = state;
        rd_valid  = 1'b0;
        busy      = 1'b0;
        rd_last   = 1'b0;
        rd_data   = '0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                rd_valid = 1'b1;
                busy     = 1'b1;
                rd_last  = last_ch;
                rd_data  = shadow[ch_r];
                if (rd_ready && last_ch) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture from pre-update counts, and channel index advance on each accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
            ch_r <= '0;
        end else if (state == IDLE && snap_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= cnt[i];
            end
            ch_r <= '0;
        end else if (state == SEND && rd_ready) begin
            ch_r <= last_ch ? '0 : ch_r + 1'b1;
        end
    end

endmodule
